minimax_mmio_uart: RTL

Memory-mapped peripheral on the minimax data bus (`addr`/`wdata`/`wmask`/`rreq`/`rdata`), placed alongside the shared instruction/data RAM. It provides a buffered 8N1 serial console transmitter and a simulation/system exit register. Writing a word to the exit register latches a return code and raises a sticky halt flag for the bench or board logic. The top level muxes `rdata` between RAM and this block using `sel`.

---
 rtl/minimax_mmio_uart.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/minimax_mmio_uart.sv
// minimax MMIO block: buffered 8N1 console transmitter
// plus a sticky exit register for halting the run.
module minimax_mmio_uart #(
  parameter logic [31:0] MMIO_BASE  = 32'hFFFFFFF0,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rreq,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        txd,
  output logic        exit_valid,
  output logic [31:0] exit_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div, div_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    sh, sh_n;
  logic          pop;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, count;
  logic        full, empty, ovf;
  logic [7:0]  head;

  logic        wr, wr_tx, wr_st, wr_exit;
  logic        rd_st, rd_exit;
  logic        push_ok, div_end;
  logic [31:0] status, rd_val;
  logic        unused_addr;

  assign sel     = addr[31:4] == MMIO_BASE[31:4];
  assign wr      = sel && (wmask == 4'hF);
  assign wr_tx   = wr && (addr[3:2] == 2'd0);
  assign wr_st   = wr && (addr[3:2] == 2'd1);
  assign wr_exit = wr && (addr[3:2] == 2'd3);
  assign rd_st   = addr[3:2] == 2'd1;
  assign rd_exit = addr[3:2] == 2'd3;

  assign unused_addr = &{1'b0, addr[1:0]};

  assign count   = wptr - rptr;
  assign full    = count == FULL_CNT;
  assign empty   = wptr == rptr;
  assign head    = mem[rptr[AW-1:0]];
  assign push_ok = wr_tx && !full;
  assign div_end = div == DIV_LAST;

  assign status = {28'd0, ovf, state != IDLE, empty, full};

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wptr[AW-1:0]] <= wdata[7:0];
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok)
        wptr <= wptr + (AW+1)'(1);
      if (pop)
        rptr <= rptr + (AW+1)'(1);
      if (wr_tx && full)
        ovf <= 1'b1;
      else if (wr_st && wdata[3])
        ovf <= 1'b0;
    end
  end

  // First EXIT write wins and sticks until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exit_valid <= 1'b0;
      exit_code  <= '0;
    end else if (wr_exit && !exit_valid) begin
      exit_valid <= 1'b1;
      exit_code  <= wdata;
    end
  end

  // Read mux over pre-edge register values
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      rd_st:   rd_val = status;
      rd_exit: rd_val = exit_code;
      default: rd_val = '0;
    endcase
  end

  // Registered read data, held when not addressed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (rreq && sel)
      rdata <= rd_val;
  end

  // UART state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      div   <= '0;
      bitc  <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      div   <= div_n;
      bitc  <= bitc_n;
      sh    <= sh_n;
    end
  end

  // UART next state, pop and serial line
  always_comb begin
    state_n = state;
    div_n   = div;
    bitc_n  = bitc;
    sh_n    = sh;
    pop     = 1'b0;
    txd     = 1'b1;
    unique case (state)
      IDLE: begin
        div_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_n    = head;
          state_n = START;
        end
      end
      START: begin
        txd   = 1'b0;
        div_n = div_end ? '0 : div + DW'(1);
        if (div_end) begin
          bitc_n  = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        txd   = sh[0];
        div_n = div_end ? '0 : div + DW'(1);
        if (div_end) begin
          sh_n = {1'b0, sh[7:1]};
          if (bitc == 3'd7) begin
            bitc_n  = '0;
            state_n = STOP;
          end else begin
            bitc_n = bitc + 3'd1;
          end
        end
      end
      STOP: begin
        txd   = 1'b1;
        div_n = div_end ? '0 : div + DW'(1);
        if (div_end) begin
          if (!empty) begin
            pop     = 1'b1;
            sh_n    = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
